// File: rtl/ddr3_arb_pkg.sv
// Shared widths and encodings for the ddr3_ctrl line-port arbiter.
package ddr3_arb_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;
endpackage

// File: rtl/ddr3_arbiter_if.sv
// Requester-side and ddr3_ctrl-side signals of the arbiter, bundled as one interface.
interface ddr3_arbiter_if #(
  parameter int unsigned NUM_PORTS = 2
) ();
  import ddr3_arb_pkg::*;

  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS*LINE_W-1:0] req_wdata_i;
  logic [NUM_PORTS-1:0]        req_we_i;
  logic [NUM_PORTS-1:0]        req_rd_i;
  logic [NUM_PORTS-1:0]        req_ack_o;
  logic [LINE_W-1:0]           req_rdata_o;
  logic [ADDR_W-1:0]           mem_addr_o;
  logic [LINE_W-1:0]           mem_wdata_o;
  logic [LINE_W-1:0]           mem_rdata_i;
  logic                        mem_we_o;
  logic                        mem_rd_o;
  logic                        mem_ack_i;
  logic [1:0]                  grant_o;
  logic                        busy_o;
  logic                        timeout_o;

  modport slave (
    input  req_addr_i, req_wdata_i, req_we_i, req_rd_i, mem_rdata_i, mem_ack_i,
    output req_ack_o, req_rdata_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_rd_o,
           grant_o, busy_o, timeout_o
  );

  modport master (
    output req_addr_i, req_wdata_i, req_we_i, req_rd_i, mem_rdata_i, mem_ack_i,
    input  req_ack_o, req_rdata_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_rd_o,
           grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/ddr3_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from last_grant+1.
module ddr3_rr_pick
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last_grant,
  output logic                 valid,
  output logic [1:0]           winner
);
  localparam int unsigned IDX_W = (NUM_PORTS > 2) ? 2 : 1;

  logic [IDX_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = IDX_W'((32'(last_grant) + i) % NUM_PORTS);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = 2'(idx);
      end
    end
  end
endmodule

// File: rtl/ddr3_arbiter.sv
// Round-robin arbiter serialising NUM_PORTS line requesters onto one ddr3_ctrl port.
module ddr3_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  ddr3_arbiter_if.slave bus
);
  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [1:0]           last_q, last_d;
  logic [31:0]          timer_q, timer_d;
  logic [NUM_PORTS-1:0] req_vec, we_sh, ack_d;
  logic                 pick_valid;
  logic [1:0]           win;
  logic [1:0]           grant_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [LINE_W-1:0]    wdata_d, rdata_d;
  logic                 we_d, rd_d, busy_d, timeout_d;

  assign req_vec = bus.req_we_i | bus.req_rd_i;
  assign we_sh   = bus.req_we_i >> win;

  ddr3_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req        (req_vec),
    .last_grant (last_q),
    .valid      (pick_valid),
    .winner     (win)
  );

  // Every output is a register; the comb block computes all next values from the current ones.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    last_d    = last_q;
    timer_d   = timer_q;
    grant_d   = bus.grant_o;
    addr_d    = bus.mem_addr_o;
    wdata_d   = bus.mem_wdata_o;
    rdata_d   = bus.req_rdata_o;
    we_d      = bus.mem_we_o;
    rd_d      = bus.mem_rd_o;
    ack_d     = '0;
    busy_d    = bus.busy_o;
    timeout_d = bus.timeout_o;
    case (state_q)
      ST_IDLE: begin
        // A stale ack from ddr3_ctrl blocks issue rather than being matched to a new request.
        if (pick_valid && !bus.mem_ack_i) begin
          grant_d = win;
          last_d  = win;
          addr_d  = bus.req_addr_i[32'(win)*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata_i[32'(win)*LINE_W +: LINE_W];
          op_d    = we_sh[0] ? OP_WR : OP_RD;
          we_d    = we_sh[0];
          rd_d    = !we_sh[0];
          timer_d = '0;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack_i) begin
          we_d    = 1'b0;
          rd_d    = 1'b0;
          if (op_q == OP_RD) rdata_d = bus.mem_rdata_i;
          ack_d   = NUM_PORTS'(1) << bus.grant_o;
          timer_d = '0;
          state_d = ST_DONE;
        end else begin
          if (timer_q != '1) timer_d = timer_q + 32'd1;
          if (timer_q >= TIMEOUT_CYCLES - 1) timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      op_q            <= OP_RD;
      last_q          <= 2'(NUM_PORTS - 1);
      timer_q         <= '0;
      bus.grant_o     <= '0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.req_rdata_o <= '0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_rd_o    <= 1'b0;
      bus.req_ack_o   <= '0;
      bus.busy_o      <= 1'b0;
      bus.timeout_o   <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      last_q          <= last_d;
      timer_q         <= timer_d;
      bus.grant_o     <= grant_d;
      bus.mem_addr_o  <= addr_d;
      bus.mem_wdata_o <= wdata_d;
      bus.req_rdata_o <= rdata_d;
      bus.mem_we_o    <= we_d;
      bus.mem_rd_o    <= rd_d;
      bus.req_ack_o   <= ack_d;
      bus.busy_o      <= busy_d;
      bus.timeout_o   <= timeout_d;
    end
  end
endmodule

// File: tb/tb_ddr3_arbiter.sv
// Directed self-checking bench for ddr3_arbiter with two ports and a short timeout.
module tb_ddr3_arbiter;
  import ddr3_arb_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ddr3_arbiter_if #(.NUM_PORTS(NP)) bus ();

  ddr3_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_we_i    = '0;
    bus.req_rd_i    = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_we_o || bus.mem_rd_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({bus.mem_we_o, bus.mem_rd_o, bus.busy_o, bus.timeout_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got we/rd/busy/to=%b expected 0000",
               {bus.mem_we_o, bus.mem_rd_o, bus.busy_o, bus.timeout_o});
    end
    checks++;
    if (bus.req_ack_o !== 2'b00 || bus.grant_o !== 2'd0 || bus.mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: got ack=%b grant=%0d addr=%h expected 00/0/0",
               bus.req_ack_o, bus.grant_o, bus.mem_addr_o);
    end
  endtask

  task automatic test_single_write;
    logic [255:0] pat;
    pat = {32{8'hAA}};
    bus.req_addr_i[31:0]   = 32'h10;
    bus.req_wdata_i[255:0] = pat;
    bus.req_we_i           = 2'b01;
    tick();
    checks++;
    if (bus.mem_we_o !== 1'b1 || bus.mem_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_strobe: got we=%b rd=%b expected 1 0", bus.mem_we_o, bus.mem_rd_o);
    end
    checks++;
    if (bus.mem_addr_o !== 32'h10 || bus.mem_wdata_o !== pat) begin
      errors++;
      $display("FAIL wr_latch: got addr=%h data=%h expected 00000010 %h",
               bus.mem_addr_o, bus.mem_wdata_o, pat);
    end
    checks++;
    if (bus.busy_o !== 1'b1 || bus.grant_o !== 2'd0) begin
      errors++;
      $display("FAIL wr_busy: got busy=%b grant=%0d expected 1 0", bus.busy_o, bus.grant_o);
    end
    repeat (4) begin
      tick();
      checks++;
      if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin
        errors++;
        $display("FAIL wr_hold: got we=%b addr=%h expected 1 00000010",
                 bus.mem_we_o, bus.mem_addr_o);
      end
    end
    bus.mem_ack_i = 1'b1;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b01 || bus.mem_we_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_done: got ack=%b we=%b busy=%b expected 01 0 1",
               bus.req_ack_o, bus.mem_we_o, bus.busy_o);
    end
    bus.mem_ack_i = 1'b0;
    bus.req_we_i  = 2'b00;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b00 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: got ack=%b busy=%b expected 00 0", bus.req_ack_o, bus.busy_o);
    end
    tick();
    checks++;
    if (bus.mem_we_o !== 1'b0 || bus.mem_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_reissue: got we=%b rd=%b expected 0 0", bus.mem_we_o, bus.mem_rd_o);
    end
  endtask

  task automatic test_simultaneous;
    apply_reset();
    bus.req_addr_i = {32'h200, 32'h100};
    bus.req_we_i   = 2'b11;
    tick();
    checks++;
    if (bus.grant_o !== 2'd0 || bus.mem_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL sim_first: got grant=%0d addr=%h expected 0 00000100",
               bus.grant_o, bus.mem_addr_o);
    end
    bus.mem_ack_i = 1'b1;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b01) begin
      errors++;
      $display("FAIL sim_ack0: got ack=%b expected 01", bus.req_ack_o);
    end
    bus.mem_ack_i = 1'b0;
    bus.req_we_i  = 2'b10;
    tick();
    tick();
    checks++;
    if (bus.grant_o !== 2'd1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL sim_second: got grant=%0d we=%b addr=%h expected 1 1 00000200",
               bus.grant_o, bus.mem_we_o, bus.mem_addr_o);
    end
    bus.mem_ack_i = 1'b1;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b10) begin
      errors++;
      $display("FAIL sim_ack1: got ack=%b expected 10", bus.req_ack_o);
    end
    bus.mem_ack_i = 1'b0;
    bus.req_we_i  = 2'b00;
    tick();
  endtask

  task automatic test_rotation;
    bit         ok;
    logic [1:0] exp_g;
    apply_reset();
    bus.req_addr_i = {32'h2000, 32'h1000};
    bus.req_rd_i   = 2'b11;
    for (int t = 0; t < 6; t++) begin
      exp_g = 2'(t % 2);
      wait_strobe(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rot_strobe: got no strobe in 20 cycles expected strobe (txn %0d)", t);
      end
      checks++;
      if (bus.grant_o !== exp_g) begin
        errors++;
        $display("FAIL rot_grant: got %0d expected %0d (txn %0d)", bus.grant_o, exp_g, t);
      end
      bus.mem_ack_i = 1'b1;
      tick();
      checks++;
      if (bus.req_ack_o !== (2'b01 << exp_g)) begin
        errors++;
        $display("FAIL rot_ack: got %b expected %b (txn %0d)",
                 bus.req_ack_o, 2'b01 << exp_g, t);
      end
      bus.mem_ack_i = 1'b0;
      tick();
    end
    bus.req_rd_i = 2'b00;
    tick();
  endtask

  task automatic test_read_data;
    bit           ok;
    logic [255:0] line;
    line          = '0;
    line[31:0]    = 32'hDEADBEEF;
    line[255:224] = 32'h12345678;
    bus.req_addr_i = {32'h300, 32'h0};
    bus.req_rd_i   = 2'b10;
    wait_strobe(ok);
    checks++;
    if (!ok || bus.mem_rd_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.grant_o !== 2'd1) begin
      errors++;
      $display("FAIL rd_issue: got ok=%b rd=%b we=%b grant=%0d expected 1 1 0 1",
               ok, bus.mem_rd_o, bus.mem_we_o, bus.grant_o);
    end
    bus.mem_rdata_i = line;
    bus.mem_ack_i   = 1'b1;
    tick();
    checks++;
    if (bus.req_rdata_o[31:0] !== 32'hDEADBEEF || bus.req_ack_o !== 2'b10) begin
      errors++;
      $display("FAIL rd_data: got data=%h ack=%b expected deadbeef 10",
               bus.req_rdata_o[31:0], bus.req_ack_o);
    end
    bus.mem_ack_i   = 1'b0;
    bus.req_rd_i    = 2'b00;
    bus.mem_rdata_i = '1;
    tick();
    bus.req_addr_i = {32'h0, 32'h400};
    bus.req_we_i   = 2'b01;
    wait_strobe(ok);
    bus.mem_ack_i = 1'b1;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b01 || bus.req_rdata_o !== line) begin
      errors++;
      $display("FAIL rd_keep: got ack=%b data=%h expected 01 %h",
               bus.req_ack_o, bus.req_rdata_o, line);
    end
    bus.mem_ack_i = 1'b0;
    bus.req_we_i  = 2'b00;
    tick();
  endtask

  task automatic test_timeout;
    bit ok;
    bus.req_addr_i = {32'h0, 32'h500};
    bus.req_we_i   = 2'b01;
    wait_strobe(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_strobe: got no strobe expected strobe");
    end
    repeat (15) tick();
    checks++;
    if (bus.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL to_early: got %b expected 0 after 15 cycles", bus.timeout_o);
    end
    tick();
    checks++;
    if (bus.timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL to_set: got %b expected 1 after 16 cycles", bus.timeout_o);
    end
    repeat (4) tick();
    checks++;
    if (bus.timeout_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL to_hold: got to=%b we=%b busy=%b expected 1 1 1",
               bus.timeout_o, bus.mem_we_o, bus.busy_o);
    end
    bus.mem_ack_i = 1'b1;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b01) begin
      errors++;
      $display("FAIL to_late_ack: got %b expected 01", bus.req_ack_o);
    end
    bus.mem_ack_i = 1'b0;
    bus.req_we_i  = 2'b00;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b00 || bus.timeout_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL to_sticky: got ack=%b to=%b busy=%b expected 00 1 0",
               bus.req_ack_o, bus.timeout_o, bus.busy_o);
    end
  endtask

  task automatic test_reset_mid_busy;
    bit ok;
    bus.req_addr_i = {32'h0, 32'h600};
    bus.req_we_i   = 2'b01;
    wait_strobe(ok);
    checks++;
    if (!ok || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got ok=%b busy=%b expected 1 1", ok, bus.busy_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_we_o, bus.mem_rd_o, bus.req_ack_o, bus.busy_o, bus.timeout_o} !== 6'b0) begin
      errors++;
      $display("FAIL rst_async: got we/rd/ack/busy/to=%b expected 000000",
               {bus.mem_we_o, bus.mem_rd_o, bus.req_ack_o, bus.busy_o, bus.timeout_o});
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.mem_we_o !== 1'b1 || bus.grant_o !== 2'd0 || bus.mem_addr_o !== 32'h600) begin
      errors++;
      $display("FAIL rst_reissue: got we=%b grant=%0d addr=%h expected 1 0 00000600",
               bus.mem_we_o, bus.grant_o, bus.mem_addr_o);
    end
    bus.mem_ack_i = 1'b1;
    tick();
    checks++;
    if (bus.req_ack_o !== 2'b01 || bus.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_complete: got ack=%b to=%b expected 01 0", bus.req_ack_o, bus.timeout_o);
    end
    bus.mem_ack_i = 1'b0;
    bus.req_we_i  = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_rotation();
    test_read_data();
    test_timeout();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
